regfile_wb_arbiter: RTL

//  Shares the register file's single write port (nD/D/RegWE) among NREQ write-back requesters in one SP core.

---
 rtl/regfile_wb_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port (nD/D/RegWE) among NREQ
// write-back requesters, such as the ALU, the load unit and the special-register
// init path.
//
// Each requester has a valid/ready handshake. A combinational arbiter picks one
// winner per cycle. The winner's write is captured in a one-deep registered
// stage, and that stage drives the register file write port directly.
//
// A write to R0 completes the handshake but never raises RegWE. R0 holds the
// core ID and is reserved.
//
// Configuration macro:
//   WB_FIXED_PRIO_EN
//     undefined (default) : round-robin arbitration. Search starts at
//                           last_grant+1.
//     defined             : fixed priority, lowest index wins. No pointer is
//                           kept.
//
// Ports:
//   clk           clock; all state updates on posedge
//   Reset_n       asynchronous active-low reset
//   req_valid     [NREQ]      requester i has a write pending
//   req_ready     [NREQ]      one-hot or zero; requester i accepted this cycle
//   req_nD        [NREQ*AW]   dest register index, requester i at [i*AW +: AW]
//   req_D         [NREQ*DW]   write data, requester i at [i*DW +: DW]
//   wb_hold       1 = accept nothing; the output stage drains
//   nD            registered write index to the register file
//   D             registered write data to the register file
//   RegWE         registered write enable to the register file
//   conflict_cnt  saturating count of un-held cycles with >=2 valid requests
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned DW   = 16,
   parameter int unsigned AW   = 4,
   parameter int unsigned CNTW = 8
) (
   input  logic                 clk,
   input  logic                 Reset_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_nD,
   input  logic [NREQ*DW-1:0]   req_D,
   input  logic                 wb_hold,
   output logic [AW-1:0]        nD,
   output logic [DW-1:0]        D,
   output logic                 RegWE,
   output logic [CNTW-1:0]      conflict_cnt
);

   localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [GW-1:0] win;
   logic          found;
   logic          xfer;
   logic          multi;
   logic [AW-1:0] sel_nD;
   logic [DW-1:0] sel_D;

`ifndef WB_FIXED_PRIO_EN
   logic [GW-1:0] last_grant;

   // The rotating search is done as two linear passes. The first pass looks
   // only at indices above last_grant. The second pass wraps around to the
   // lowest valid index. This avoids a modulo on a variable index.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && (GW'(i) > last_grant)) begin
            found = 1'b1;
            win   = GW'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            win   = GW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         last_grant <= GW'(NREQ - 1);
      end else if (xfer) begin
         last_grant <= win;
      end
   end
`else
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            win   = GW'(i);
         end
      end
   end
`endif

   assign xfer = found & ~wb_hold;

   // ready is forced low during reset, even though the async reset already
   // holds every flop.
   always_comb begin
      req_ready = '0;
      if (xfer && Reset_n) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == GW'(i)) begin
               req_ready[i] = 1'b1;
            end
         end
      end
   end

   // Winner payload mux.
   always_comb begin
      sel_nD = '0;
      sel_D  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win == GW'(i)) begin
            sel_nD = req_nD[i*AW +: AW];
            sel_D  = req_D[i*DW +: DW];
         end
      end
   end

   // Contention detect: two or more valid requests.
   always_comb begin
      logic seen_one;
      seen_one = 1'b0;
      multi    = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_valid[i]) begin
            if (seen_one) begin
               multi = 1'b1;
            end
            seen_one = 1'b1;
         end
      end
   end

   // Output stage. An accepted write to R0 still updates nD/D but leaves
   // RegWE low.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         nD    <= '0;
         D     <= '0;
         RegWE <= 1'b0;
      end else if (xfer) begin
         nD    <= sel_nD;
         D     <= sel_D;
         RegWE <= (sel_nD != '0);
      end else begin
         RegWE <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         conflict_cnt <= '0;
      end else if (!wb_hold && multi && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule
